axis_s: RTL
===========

AXIS_S -- requirements
Module: axis_s

Parameters
REQ-001 DATA_W, default 8, SHALL set the width of tdata and dout.
REQ-002 DEPTH, default 16, SHALL set the number of FIFO entries and SHALL be a power of two.

Interface
REQ-003 s_axis_aclk  in  1  SHALL be the single clock; all logic SHALL run on its rising edge.
REQ-004 s_axis_aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_axis_tdata  in  DATA_W  SHALL carry the stream data beat.
REQ-006 s_axis_tvalid  in  1  SHALL indicate that the upstream master presents a valid beat.
REQ-007 s_axis_tlast  in  1  SHALL mark the final beat of a packet.
REQ-008 s_axis_tready  out  1  SHALL indicate that this block can accept a beat.
REQ-009 dout  out  DATA_W  SHALL show the data of the FIFO head entry.
REQ-010 dout_last  out  1  SHALL show the tlast flag of the FIFO head entry.
REQ-011 dout_valid  out  1  SHALL indicate that the head entry is valid.
REQ-012 rd_en  in  1  SHALL be the consumer pop request.
REQ-013 pkt_count  out  8  SHALL count completed packets, wrapping modulo 256.
REQ-014 pkt_len  out  8  SHALL hold the beat count of the last completed packet.
REQ-015 fifo_full, fifo_empty  out  1 each  SHALL report the FIFO status.

Function
REQ-016 A beat SHALL be accepted exactly on a rising edge where s_axis_tvalid=1 and s_axis_tready=1.
REQ-017 Each accepted beat SHALL write {tlast, tdata} to the FIFO at wr_ptr, and wr_ptr SHALL then increment modulo DEPTH.
REQ-018 s_axis_tready SHALL equal !fifo_full, so no beat is ever dropped.
REQ-019 The output SHALL be first-word-fall-through: dout, dout_last and dout_valid=!fifo_empty SHALL be valid in the same cycle the entry exists, with no read latency.
REQ-020 A pop SHALL occur when rd_en=1 and dout_valid=1; rd_en while empty SHALL be ignored with no pointer change.
REQ-021 Write-to-read latency SHALL be one cycle: a beat accepted at edge N SHALL appear on dout after edge N.
REQ-022 Simultaneous push and pop SHALL leave the occupancy unchanged and update both pointers.
REQ-023 Occupancy SHALL be held in a count of width log2(DEPTH)+1; fifo_full SHALL equal (count==DEPTH) and fifo_empty SHALL equal (count==0).
REQ-024 When the FIFO is full, s_axis_tready=0 SHALL block the push even if rd_en pops in the same cycle; tready SHALL rise on the following cycle.
REQ-025 The FSM SHALL have two states, IDLE and RECV; beat_cnt SHALL be an internal 8-bit counter.
REQ-026 IDLE SHALL behave as follows:
  - accepted beat with tlast=0 -> go to RECV with beat_cnt=1;
  - accepted beat with tlast=1 -> stay in IDLE, pkt_len=1, pkt_count+1.
REQ-027 RECV SHALL behave as follows:
  - accepted beat with tlast=0 -> beat_cnt+1, saturating at 255;
  - accepted beat with tlast=1 -> pkt_len=beat_cnt+1 (saturating at 255), pkt_count+1, beat_cnt=0, go to IDLE.
REQ-028 With no accepted beat, the FSM, beat_cnt, pkt_len and pkt_count SHALL hold their values.
REQ-029 pkt_count SHALL wrap from 255 to 0.

Reset
REQ-030 Assertion of s_axis_aresetn=0 SHALL immediately, without waiting for a clock edge, clear wr_ptr, rd_ptr, count, beat_cnt, pkt_len, pkt_count and dout_last, and set dout_valid=0.
REQ-031 During reset the FSM SHALL be in IDLE, fifo_empty SHALL be 1, fifo_full SHALL be 0, and s_axis_tready SHALL be 0.
REQ-032 On the first rising edge after reset release, s_axis_tready SHALL become 1.
REQ-033 Reset asserted mid-packet or with the FIFO non-empty SHALL discard all stored and partial data, and no pkt_count update SHALL occur.
REQ-034 FIFO memory contents need not be cleared by reset.

Verification
REQ-035 Bench SHALL cover: reset, then tvalid=1 with tlast=0 for beats 0x11,0x22,0x33 and tlast=1 on 0x44, rd_en=1 -> dout sequence 11,22,33,44, dout_last=1 only on 44, pkt_len=4, pkt_count=1.
REQ-036 Bench SHALL cover: rd_en=0 with 16 single-beat packets pushed -> fifo_full=1, s_axis_tready=0, and a 17th beat held by the master until one pop, then accepted; pkt_count=17.
REQ-037 Bench SHALL cover: continuous push and pop at half occupancy -> count stable, data order preserved, and rd_ptr wrapping past 15 without corruption.
REQ-038 Bench SHALL cover: reset asserted after 2 beats of a packet with tlast=0 -> fifo_empty=1, pkt_count=0, and the next 1-beat packet giving pkt_len=1.
REQ-039 Bench SHALL cover: a 300-beat packet with the consumer always ready -> pkt_len=255 (saturated) and pkt_count+1.
REQ-040 Bench SHALL cover: 256 single-beat packets -> pkt_count returns to 0.

Source files
------------

// File: rtl/axis_s.sv
// rtl/axis_s.sv - AXI-Stream slave into a first-word-fall-through FIFO with packet length/count tracking
module axis_s #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              rd_en,
    output logic [7:0]        pkt_count,
    output logic [7:0]        pkt_len,
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RECV} state_t;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            rdy_q;
    logic            push;
    logic            pop;

    state_t          state_q;
    logic [7:0]      beat_cnt_q;
    logic [7:0]      pkt_len_q;
    logic [7:0]      pkt_count_q;

    assign push = s_axis_tvalid & rdy_q;
    assign pop  = rd_en & ~fifo_empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Ready is registered from the next occupancy, so it stays low in reset and
    // a pop from a full FIFO only reopens the input on the following cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            rdy_q   <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            pkt_len_q   <= '0;
            pkt_count_q <= '0;
        end else if (push) begin
            case (state_q)
                IDLE: begin
                    if (s_axis_tlast) begin
                        pkt_len_q   <= 8'd1;
                        pkt_count_q <= pkt_count_q + 8'd1;
                    end else begin
                        beat_cnt_q <= 8'd1;
                        state_q    <= RECV;
                    end
                end
                RECV: begin
                    if (s_axis_tlast) begin
                        pkt_len_q   <= (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
                        pkt_count_q <= pkt_count_q + 8'd1;
                        beat_cnt_q  <= '0;
                        state_q     <= IDLE;
                    end else if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_full     = (count_q == CW'(DEPTH));
    assign fifo_empty    = (count_q == '0);
    assign s_axis_tready = rdy_q;
    assign dout_valid    = ~fifo_empty;
    assign dout          = mem_q[rd_ptr_q][DATA_W-1:0];
    assign dout_last     = ~fifo_empty & mem_q[rd_ptr_q][DATA_W];
    assign pkt_count     = pkt_count_q;
    assign pkt_len       = pkt_len_q;

endmodule
